// File: rtl/gomoku_kb_pkg.sv
// Shared keypad types: debounce state and frame-result encodings, plus the row decoder
// used by every block that samples the keypad rows.
package gomoku_kb_pkg;

  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressPend   = 2'd1,
    StPressed     = 2'd2,
    StReleasePend = 2'd3
  } db_state_e;

  typedef enum logic [1:0] {
    FrNone   = 2'd0,
    FrSingle = 2'd1,
    FrMulti  = 2'd2
  } frame_res_e;

  typedef struct packed {
    frame_res_e  res;
    logic [1:0]  row_idx;
  } row_dec_t;

  // Rows are active-low with row0 on bit 3.
  function automatic row_dec_t row_decode(input logic [3:0] row);
    row_dec_t d;
    d.res     = FrNone;
    d.row_idx = 2'd0;
    case (row)
      4'b1111: d.res = FrNone;
      4'b0111: begin d.res = FrSingle; d.row_idx = 2'd0; end
      4'b1011: begin d.res = FrSingle; d.row_idx = 2'd1; end
      4'b1101: begin d.res = FrSingle; d.row_idx = 2'd2; end
      4'b1110: begin d.res = FrSingle; d.row_idx = 2'd3; end
      default: d.res = FrMulti;
    endcase
    return d;
  endfunction

  // Active-low one-hot column drive with col0 on bit 3.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/gomoku_kb_debounce.sv
// Frame-rate debounce FSM: turns per-frame scan results into one event per press and a
// held level that lasts until the debounced release.
module gomoku_kb_debounce
  import gomoku_kb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_frame_valid,
  input  frame_res_e i_frame_res,
  input  logic [3:0] i_frame_code,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  output logic       o_key_held
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_FRAMES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  db_state_e       r_state, w_state_d;
  logic [3:0]      r_cand, w_cand_d;
  logic [CntW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic            r_valid, w_event;
  logic [3:0]      r_code;
  logic            w_hit, w_none;

  assign w_hit     = (i_frame_res == FrSingle);
  assign w_none    = (i_frame_res == FrNone);
  assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CntOne;

  always_comb begin
    w_state_d = r_state;
    w_cand_d  = r_cand;
    w_cnt_d   = r_cnt;
    w_event   = 1'b0;
    if (i_frame_valid) begin
      case (r_state)
        StReleased: begin
          if (w_hit) begin
            w_cand_d = i_frame_code;
            if (CntOne == CntMax) begin
              w_state_d = StPressed;
              w_cnt_d   = '0;
              w_event   = 1'b1;
            end else begin
              w_state_d = StPressPend;
              w_cnt_d   = CntOne;
            end
          end
        end
        StPressPend: begin
          if (w_hit && (i_frame_code == r_cand)) begin
            if (w_cnt_inc == CntMax) begin
              w_state_d = StPressed;
              w_cnt_d   = '0;
              w_event   = 1'b1;
            end else begin
              w_cnt_d = w_cnt_inc;
            end
          end else if (w_hit) begin
            w_cand_d = i_frame_code;
            w_cnt_d  = CntOne;
          end else begin
            w_state_d = StReleased;
            w_cnt_d   = '0;
          end
        end
        StPressed: begin
          if (w_none) begin
            if (CntOne == CntMax) begin
              w_state_d = StReleased;
              w_cnt_d   = '0;
            end else begin
              w_state_d = StReleasePend;
              w_cnt_d   = CntOne;
            end
          end
        end
        StReleasePend: begin
          if (w_none) begin
            if (w_cnt_inc == CntMax) begin
              w_state_d = StReleased;
              w_cnt_d   = '0;
            end else begin
              w_cnt_d = w_cnt_inc;
            end
          end else begin
            w_state_d = StPressed;
            w_cnt_d   = '0;
          end
        end
        default: begin
          w_state_d = StReleased;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= StReleased;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_code  <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_cand  <= w_cand_d;
      r_cnt   <= w_cnt_d;
      r_valid <= w_event;
      if (w_event) r_code <= w_cand_d;
    end
  end

  assign o_key_valid = r_valid;
  assign o_key_code  = r_code;
  assign o_key_held  = (r_state == StPressed) || (r_state == StReleasePend);

endmodule

// File: rtl/gomoku_kb_input_ctrl.sv
// 4x4 keypad front end: column scanner, per-frame hit accumulator, debounce and the
// X/Y coordinate latch feeding the move logic.
module gomoku_kb_input_ctrl
  import gomoku_kb_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] keyboard_row,
  output logic [3:0] keyboard_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  input  logic       pos_clear,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y,
  output logic       pos_x_set,
  output logic       pos_y_set,
  output logic       pos_ready
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);

  logic             w_clr;
  logic             r_run;
  logic [1:0]       r_col_idx;
  logic [SlotW-1:0] r_slot;
  frame_res_e       r_acc_res, w_acc_res, r_fr_res;
  logic [3:0]       r_acc_code, w_acc_code, r_fr_code;
  logic             r_fr_valid;
  row_dec_t         w_dec;
  logic [2:0]       r_pos_x, r_pos_y;
  logic             r_x_set, r_y_set, w_x_set_d, w_y_set_d;

  assign w_clr = rst | ~en;
  assign w_dec = row_decode(keyboard_row);

  // Fold this slot's sample into the running frame result.
  always_comb begin
    w_acc_res  = r_acc_res;
    w_acc_code = r_acc_code;
    if (w_dec.res == FrMulti) begin
      w_acc_res = FrMulti;
    end else if (w_dec.res == FrSingle) begin
      if (r_acc_res == FrNone) begin
        w_acc_res  = FrSingle;
        w_acc_code = {w_dec.row_idx, r_col_idx};
      end else begin
        w_acc_res = FrMulti;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_run      <= 1'b0;
      r_col_idx  <= 2'd0;
      r_slot     <= '0;
      r_acc_res  <= FrNone;
      r_acc_code <= 4'd0;
      r_fr_valid <= 1'b0;
      r_fr_res   <= FrNone;
      r_fr_code  <= 4'd0;
    end else begin
      r_run      <= 1'b1;
      r_fr_valid <= 1'b0;
      if (r_run) begin
        if (r_slot == SlotLast) begin
          r_slot    <= '0;
          r_col_idx <= r_col_idx + 2'd1;
          if (r_col_idx == 2'd3) begin
            r_fr_valid <= 1'b1;
            r_fr_res   <= w_acc_res;
            r_fr_code  <= w_acc_code;
            r_acc_res  <= FrNone;
            r_acc_code <= 4'd0;
          end else begin
            r_acc_res  <= w_acc_res;
            r_acc_code <= w_acc_code;
          end
        end else begin
          r_slot <= r_slot + SlotW'(1);
        end
      end
    end
  end

  assign keyboard_col = r_run ? col_drive(r_col_idx) : 4'hF;

  gomoku_kb_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .i_clk         (clk),
    .i_clr         (w_clr),
    .i_frame_valid (r_fr_valid),
    .i_frame_res   (r_fr_res),
    .i_frame_code  (r_fr_code),
    .o_key_valid   (key_valid),
    .o_key_code    (key_code),
    .o_key_held    (key_held)
  );

  // A clear coincident with a key event loses to the event for the field just keyed.
  always_comb begin
    w_x_set_d = pos_clear ? 1'b0 : r_x_set;
    w_y_set_d = pos_clear ? 1'b0 : r_y_set;
    if (key_valid) begin
      if (key_code[3]) w_x_set_d = 1'b1;
      else             w_y_set_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_pos_x <= 3'd0;
      r_pos_y <= 3'd0;
      r_x_set <= 1'b0;
      r_y_set <= 1'b0;
    end else begin
      r_x_set <= w_x_set_d;
      r_y_set <= w_y_set_d;
      if (key_valid && key_code[3])  r_pos_x <= key_code[2:0];
      if (key_valid && !key_code[3]) r_pos_y <= key_code[2:0];
    end
  end

  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign pos_x_set = r_x_set;
  assign pos_y_set = r_y_set;
  assign pos_ready = r_x_set & r_y_set;

endmodule

// File: tb/tb_gomoku_kb_input_ctrl.sv
// Bench for the keypad controller: a keypad model answers the driven column, expected key
// codes queue up when a press is applied and are matched against each key_valid pulse.
module tb_gomoku_kb_input_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, pos_clear;
  logic [3:0] keyboard_row, keyboard_col, key_code;
  logic       key_valid, key_held, pos_x_set, pos_y_set, pos_ready;
  logic [2:0] pos_x, pos_y;
  logic [15:0] keys;

  int n_checks = 0;
  int n_pass   = 0;
  int n_events = 0;
  int ev0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_cols[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic       kv_prev = 1'b0;

  always #5 clk = ~clk;

  gomoku_kb_input_ctrl #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .keyboard_row (keyboard_row),
    .keyboard_col (keyboard_col),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_held     (key_held),
    .pos_clear    (pos_clear),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_x_set    (pos_x_set),
    .pos_y_set    (pos_y_set),
    .pos_ready    (pos_ready)
  );

  // Key k sits at row k/4, col k%4; row0/col0 are bit 3 of the buses.
  always_comb begin
    keyboard_row = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && !keyboard_col[3 - (k % 4)]) keyboard_row[3 - (k / 4)] = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      check("kv_width", kv_prev, 0);
      check("held_at_event", key_held, 1);
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) check("key_code", key_code, sb_q.pop_front());
      n_events++;
    end
    kv_prev = key_valid;
  end

  // Returns #1 after the edge that starts a new frame (col0, slot 0).
  task automatic next_frame();
    logic [3:0] prev;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      prev = keyboard_col;
      @(posedge clk);
      #1;
      if (keyboard_col == 4'b0111 && prev != 4'b0111) seen = 1'b1;
    end
    check("frame_start", seen, 1);
  endtask

  task automatic press_for(input int code, input int n);
    next_frame();
    keys[code] = 1'b1;
    repeat (n) next_frame();
    keys[code] = 1'b0;
    repeat (3) next_frame();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pos_clear = 1'b0; keys = '0;
    repeat (3) @(negedge clk);
    check("rst_col", keyboard_col, 4'hF);
    check("rst_kv", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_pos_x", pos_x, 0);
    check("rst_pos_y", pos_y, 0);
    check("rst_ready", pos_ready, 0);

    // Idle scan sequence
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("scan_col", keyboard_col, exp_cols[i / 4]);
    end

    // Key 9 held for 5 frames
    next_frame();
    keys[9] = 1'b1;
    sb_q.push_back(4'd9);
    next_frame();
    next_frame();
    @(negedge clk);
    check("lat_early", key_valid, 0);
    @(negedge clk);
    check("lat_event", key_valid, 1);
    repeat (3) next_frame();
    keys[9] = 1'b0;
    check("held_on", key_held, 1);
    next_frame();
    next_frame();
    check("held_pre_fall", key_held, 1);
    @(negedge clk);
    @(negedge clk);
    check("held_fall", key_held, 0);
    check("k9_pos_x", pos_x, 1);
    check("k9_x_set", pos_x_set, 1);
    check("k9_y_set", pos_y_set, 0);

    // Key 5, then clear
    sb_q.push_back(4'd5);
    press_for(5, 3);
    check("xy_pos_x", pos_x, 1);
    check("xy_pos_y", pos_y, 5);
    check("xy_ready", pos_ready, 1);
    @(negedge clk);
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    check("clr_x_set", pos_x_set, 0);
    check("clr_y_set", pos_y_set, 0);
    check("clr_pos_x", pos_x, 1);
    check("clr_pos_y", pos_y, 5);
    check("clr_ready", pos_ready, 0);

    // Bounce on key 3, then a clean 2-frame hold
    ev0 = n_events;
    next_frame();
    keys[3] = 1'b1; next_frame();
    keys[3] = 1'b0; next_frame();
    keys[3] = 1'b1; next_frame();
    keys[3] = 1'b0; next_frame();
    next_frame();
    check("bounce_none", n_events, ev0);
    sb_q.push_back(4'd3);
    keys[3] = 1'b1;
    next_frame();
    next_frame();
    keys[3] = 1'b0;
    repeat (3) next_frame();
    check("bounce_one", n_events, ev0 + 1);
    check("k3_pos_y", pos_y, 3);

    // Keys 2 and 7 together, then release 7
    ev0 = n_events;
    next_frame();
    keys[2] = 1'b1; keys[7] = 1'b1;
    repeat (3) next_frame();
    check("multi_none", n_events, ev0);
    keys[7] = 1'b0;
    sb_q.push_back(4'd2);
    next_frame();
    next_frame();
    @(negedge clk);
    @(negedge clk);
    check("multi_rel_event", key_valid, 1);
    keys[2] = 1'b0;
    repeat (3) next_frame();

    // en dropped in the middle of PRESS_PEND
    ev0 = n_events;
    next_frame();
    keys[12] = 1'b1;
    next_frame();
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_col", keyboard_col, 4'hF);
    check("en_code", key_code, 0);
    check("en_held", key_held, 0);
    check("en_pos_x", pos_x, 0);
    check("en_pos_y", pos_y, 0);
    check("en_x_set", pos_x_set, 0);
    check("en_y_set", pos_y_set, 0);
    repeat (20) @(negedge clk);
    check("idle_col", keyboard_col, 4'hF);
    keys[12] = 1'b0;
    en = 1'b1;
    @(negedge clk);
    check("restart_col", keyboard_col, 4'b0111);
    repeat (3) next_frame();
    check("en_no_event", n_events, ev0);

    // rst in the middle of PRESS_PEND
    sb_q.push_back(4'd9);
    press_for(9, 3);
    ev0 = n_events;
    next_frame();
    keys[12] = 1'b1;
    next_frame();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_col", keyboard_col, 4'hF);
    check("rst2_code", key_code, 0);
    check("rst2_pos_x", pos_x, 0);
    check("rst2_x_set", pos_x_set, 0);
    check("rst2_held", key_held, 0);
    keys[12] = 1'b0;
    rst = 1'b0;
    repeat (3) next_frame();
    check("rst2_no_event", n_events, ev0);

    // pos_clear coincident with key 12
    sb_q.push_back(4'd5);
    press_for(5, 3);
    check("pre_y_set", pos_y_set, 1);
    next_frame();
    keys[12] = 1'b1;
    sb_q.push_back(4'd12);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (key_valid) break;
    end
    check("kv_seen", key_valid, 1);
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    check("coin_x_set", pos_x_set, 1);
    check("coin_y_set", pos_y_set, 0);
    check("coin_pos_x", pos_x, 4);
    check("coin_pos_y", pos_y, 5);
    keys[12] = 1'b0;
    repeat (3) next_frame();

    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
